alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Single-issue operation sequencer that sits directly upstream of alu_ip and drives its sel/A/B inputs.
- It also consumes the C/Z outputs.
- Holds a small signed register file, accepts operation requests over a valid/ready handshake, and issues registered operands to the combinational ALU.
- Captures C/Z, writes the result back, and presents it on a valid/ready result port.

Parameters:
- N, 8, operand/result width; must match alu_ip N.
- NREG, 8, number of registers (power of two, >=2); AW = $clog2(NREG) derived localparam.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  3  ALU select, passed unchanged to sel
- in_rd  in  AW  destination register
- in_ra  in  AW  source register A
- in_rb  in  AW  source register B
- in_imm_en  in  1  1: B operand = in_imm instead of reg[in_rb]
- in_imm  in  N  signed immediate
- sel  out  3  to alu_ip sel
- A  out  N  signed, to alu_ip A
- B  out  N  signed, to alu_ip B
- C  in  N  signed, from alu_ip
- Z  in  1  from alu_ip zero flag
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when res_valid && res_ready
- res_data  out  N  captured C
- res_zero  out  1  captured Z
- res_rd  out  AW  destination of the captured result

Behaviour:
- FSM states: IDLE, ISSUE, HOLD.
- Reset (rst=1 at clk edge) values:
  - state=IDLE; sel=0, A=0, B=0
  - res_valid=0, res_data=0, res_zero=0, res_rd=0
  - all registers=0
  - Applies from any state; any in-flight op is discarded and no write-back occurs.
- in_ready = (state==IDLE) || (state==HOLD && res_ready). This is a combinational path from res_ready; it must not depend on in_valid.
- Accept edge (in_valid && in_ready):
  - register sel<=in_op, A<=reg[in_ra], B<=in_imm_en ? in_imm : reg[in_rb], res_rd<=in_rd
  - state->ISSUE
- ISSUE: one cycle for the ALU to settle. On the next edge:
  - res_data<=C, res_zero<=Z, res_valid<=1
  - reg[res_rd]<=C, unless res_rd==0
  - state->HOLD
- HOLD: outputs stable while res_valid && !res_ready. Transitions:
  - res_ready=1, no new request: res_valid<=0, state->IDLE.
  - res_ready=1 and in_valid=1: new request accepted on the same edge, res_valid<=0, state->ISSUE.
- Latency: accept edge to res_valid high = 2 edges. Peak throughput is 1 op per 2 cycles.
- Register 0 always reads 0. Writes to it are dropped, but the result is still reported on res_data.
- No hazards: write-back completes before the next accept edge, so an op reading the previous rd sees the new value.
- sel/A/B hold their last values in IDLE/HOLD (no glitching to 0).
- in_* ignored when in_ready=0.
- Arithmetic is entirely in alu_ip; this block performs no width extension or truncation.

Optional Feature:
- Macro ALU_ISSUE_ZCNT_EN.
- Defined:
  - adds output port zcount, 16 bits.
  - zcount increments by 1 on every ISSUE->HOLD edge where Z=1; saturates at 16'hFFFF; reset to 0 by rst.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package alu_pkg holds:
  - typedef alu_sel_t (logic [2:0])
  - typedef enum issue_state_t {IDLE, ISSUE, HOLD}
  - ALU_OP_ADD = 3'b000
- One natural sub-module: alu_regfile (NREG x N, 2 async read ports, 1 sync write port, R0 hardwired zero, synchronous reset clears all).
- Top-level bench instantiates alu_issue_ctrl connected to the real alu_ip #(.N(8)).

Test Plan:
1. Reset mid-ISSUE: request accepted, then rst on the next edge. Required: res_valid=0, state IDLE, target register still 0, in_ready=1.
2. Immediate load: op=ADD, ra=0, imm_en=1, imm=5, rd=1. Required: res_valid high 2 edges after accept, res_data=5, res_zero=0, reg1=5. Repeat with imm=10, rd=2.
3. Register-register op: op=ADD, ra=1, rb=2, rd=3 with res_ready=1. Required:
   - sel=000, A=5, B=10 during ISSUE
   - res_data=15, res_rd=3
   - in_ready=1 in the HOLD cycle
4. Back-to-back with res_ready=1: ADD r4=r0+imm(-10), then ADD r5=r4+imm(10) accepted in HOLD. Required: second result res_data=0, res_zero=1, no idle cycle between ops.
5. Backpressure: res_ready=0 for 5 cycles in HOLD. Required: res_data/res_zero/res_rd stable, in_ready=0, in_valid ignored. Raising res_ready completes the transfer once.
6. R0 write: ADD rd=0 with imm=7. Required: res_data=7, subsequent read of r0 gives A=0. With ALU_ISSUE_ZCNT_EN, zcount equals the number of Z=1 results, e.g. 1 after scenario 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller and its register file.
package alu_pkg;

  typedef logic [2:0] alu_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } issue_state_t;

  localparam alu_sel_t ALU_OP_ADD = 3'b000;

endpackage

// File: rtl/alu_regfile.sv
// NREG x N register file: two asynchronous read ports, one synchronous write port,
// register 0 hardwired to zero, synchronous reset clears every entry.
module alu_regfile #(
  parameter int N    = 8,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(NREG)-1:0] ra_addr,
  input  logic [$clog2(NREG)-1:0] rb_addr,
  output logic [N-1:0]            ra_data,
  output logic [N-1:0]            rb_data,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic [N-1:0]            wd
);

  logic [N-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Register 0 reads as zero regardless of storage contents.
  assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer feeding alu_ip: registers operands, captures C/Z, writes back.
// Optional Z=1 result counter on port zcount when ALU_ISSUE_ZCNT_EN is defined.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic [$clog2(NREG)-1:0] in_rd,
  input  logic [$clog2(NREG)-1:0] in_ra,
  input  logic [$clog2(NREG)-1:0] in_rb,
  input  logic                    in_imm_en,
  input  logic [N-1:0]            in_imm,
  output logic [2:0]              sel,
  output logic [N-1:0]            A,
  output logic [N-1:0]            B,
  input  logic [N-1:0]            C,
  input  logic                    Z,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [N-1:0]            res_data,
  output logic                    res_zero,
  output logic [$clog2(NREG)-1:0] res_rd
`ifdef ALU_ISSUE_ZCNT_EN
  ,
  output logic [15:0]             zcount
`endif
);

  localparam int AW = $clog2(NREG);

  issue_state_t state;
  logic [N-1:0] ra_data;
  logic [N-1:0] rb_data;
  logic         accept;
  logic         wb_en;

  alu_regfile #(.N(N), .NREG(NREG)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (in_ra),
    .rb_addr (in_rb),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .we      (wb_en),
    .wa      (res_rd),
    .wd      (C)
  );

  // Ready in HOLD depends only on res_ready so a new op can overlap the result handoff.
  assign in_ready = (state == IDLE) || ((state == HOLD) && res_ready);
  assign accept   = in_valid && in_ready;
  assign wb_en    = (state == ISSUE) && (res_rd != AW'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      A         <= '0;
      B         <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_rd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sel    <= in_op;
            A      <= ra_data;
            B      <= in_imm_en ? in_imm : rb_data;
            res_rd <= in_rd;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          res_data  <= C;
          res_zero  <= Z;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (accept) begin
              sel    <= in_op;
              A      <= ra_data;
              B      <= in_imm_en ? in_imm : rb_data;
              res_rd <= in_rd;
              state  <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_ZCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zcount <= '0;
    end else if ((state == ISSUE) && Z && (zcount != 16'hFFFF)) begin
      zcount <= zcount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU stand-in.
// Also checks zcount when ALU_ISSUE_ZCNT_EN is defined.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [2:0] in_rd;
  logic [2:0] in_ra;
  logic [2:0] in_rb;
  logic       in_imm_en;
  logic [7:0] in_imm;
  logic [2:0] sel;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] C;
  logic       Z;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_zero;
  logic [2:0] res_rd;
`ifdef ALU_ISSUE_ZCNT_EN
  logic [15:0] zcount;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Combinational ALU stand-in: ADD on sel 000, subtract otherwise.
  always_comb begin
    C = '0;
    case (sel)
      ALU_OP_ADD: C = A + B;
      default:    C = A - B;
    endcase
    Z = (C == 8'h00);
  end

  alu_issue_ctrl #(.N(8), .NREG(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .in_imm_en (in_imm_en),
    .in_imm    (in_imm),
    .sel       (sel),
    .A         (A),
    .B         (B),
    .C         (C),
    .Z         (Z),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .res_rd    (res_rd)
`ifdef ALU_ISSUE_ZCNT_EN
    ,
    .zcount    (zcount)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [2:0] rd,
                               input logic [2:0] ra, input logic [2:0] rb,
                               input logic ie, input logic [7:0] imm);
    in_valid  = v;
    in_op     = op;
    in_rd     = rd;
    in_ra     = ra;
    in_rb     = rb;
    in_imm_en = ie;
    in_imm    = imm;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst       = 1'b1;
    res_ready = 1'b1;
    applyStimulus(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    tick();
    tick();
    checkOutput("rst_res_valid", 16'(res_valid), 16'h0);
    checkOutput("rst_res_data", 16'(res_data), 16'h00);
    checkOutput("rst_res_zero", 16'(res_zero), 16'h0);
    checkOutput("rst_res_rd", 16'(res_rd), 16'h0);
    checkOutput("rst_sel", 16'(sel), 16'h0);
    checkOutput("rst_A", 16'(A), 16'h00);
    checkOutput("rst_B", 16'(B), 16'h00);
    checkOutput("rst_in_ready", 16'(in_ready), 16'h1);
    rst = 1'b0;

    $display("[TB] reset during ISSUE");
    applyStimulus(1'b1, ALU_OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h09);
    tick();
    checkOutput("s1_in_issue_not_ready", 16'(in_ready), 16'h0);
    rst = 1'b1;
    applyStimulus(1'b0, ALU_OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("s1_res_valid", 16'(res_valid), 16'h0);
    checkOutput("s1_in_ready", 16'(in_ready), 16'h1);
    applyStimulus(1'b1, ALU_OP_ADD, 3'd0, 3'd1, 3'd0, 1'b1, 8'h03);
    tick();
    checkOutput("s1_reg1_still_zero", 16'(A), 16'h00);
    checkOutput("s1_imm_B", 16'(B), 16'h03);
    applyStimulus(1'b0, ALU_OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    tick();
    checkOutput("s1_res_data", 16'(res_data), 16'h03);
    tick();
    checkOutput("s1_back_idle", 16'(res_valid), 16'h0);

    $display("[TB] immediate loads");
    applyStimulus(1'b1, ALU_OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05);
    tick();
    checkOutput("s2_valid_after_1", 16'(res_valid), 16'h0);
    applyStimulus(1'b0, ALU_OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    tick();
    checkOutput("s2_valid_after_2", 16'(res_valid), 16'h1);
    checkOutput("s2_res_data", 16'(res_data), 16'h05);
    checkOutput("s2_res_zero", 16'(res_zero), 16'h0);
    checkOutput("s2_res_rd", 16'(res_rd), 16'h1);
    tick();
    applyStimulus(1'b1, ALU_OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 8'h0A);
    tick();
    applyStimulus(1'b0, ALU_OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    tick();
    checkOutput("s2b_res_data", 16'(res_data), 16'h0A);
    checkOutput("s2b_res_rd", 16'(res_rd), 16'h2);
    tick();

    $display("[TB] register-register add");
    applyStimulus(1'b1, ALU_OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 8'hFF);
    tick();
    checkOutput("s3_sel", 16'(sel), 16'h0);
    checkOutput("s3_A", 16'(A), 16'h05);
    checkOutput("s3_B", 16'(B), 16'h0A);
    applyStimulus(1'b0, ALU_OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    tick();
    checkOutput("s3_res_data", 16'(res_data), 16'h0F);
    checkOutput("s3_res_rd", 16'(res_rd), 16'h3);
    checkOutput("s3_hold_in_ready", 16'(in_ready), 16'h1);
    tick();

    $display("[TB] back-to-back");
    applyStimulus(1'b1, ALU_OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 8'hF6);
    tick();
    applyStimulus(1'b1, ALU_OP_ADD, 3'd5, 3'd4, 3'd0, 1'b1, 8'h0A);
    tick();
    checkOutput("s4_first_data", 16'(res_data), 16'hF6);
    checkOutput("s4_first_zero", 16'(res_zero), 16'h0);
    checkOutput("s4_hold_ready", 16'(in_ready), 16'h1);
    tick();
    checkOutput("s4_second_accepted", 16'(res_valid), 16'h0);
    checkOutput("s4_A_sees_r4", 16'(A), 16'hF6);
    applyStimulus(1'b0, ALU_OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    tick();
    checkOutput("s4_second_valid", 16'(res_valid), 16'h1);
    checkOutput("s4_second_data", 16'(res_data), 16'h00);
    checkOutput("s4_second_zero", 16'(res_zero), 16'h1);
    checkOutput("s4_second_rd", 16'(res_rd), 16'h5);
`ifdef ALU_ISSUE_ZCNT_EN
    checkOutput("s4_zcount", zcount, 16'd1);
`endif
    tick();

    $display("[TB] backpressure");
    res_ready = 1'b0;
    applyStimulus(1'b1, ALU_OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 8'h21);
    tick();
    applyStimulus(1'b1, ALU_OP_ADD, 3'd7, 3'd1, 3'd0, 1'b1, 8'h44);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("s5_valid", 16'(res_valid), 16'h1);
      checkOutput("s5_data", 16'(res_data), 16'h21);
      checkOutput("s5_zero", 16'(res_zero), 16'h0);
      checkOutput("s5_rd", 16'(res_rd), 16'h6);
      checkOutput("s5_in_ready", 16'(in_ready), 16'h0);
      tick();
    end
    applyStimulus(1'b0, ALU_OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    res_ready = 1'b1;
    #1;
    checkOutput("s5_release_ready", 16'(in_ready), 16'h1);
    tick();
    checkOutput("s5_done", 16'(res_valid), 16'h0);
    tick();
    checkOutput("s5_done_once", 16'(res_valid), 16'h0);

    $display("[TB] register 0 write");
    applyStimulus(1'b1, ALU_OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 8'h07);
    tick();
    applyStimulus(1'b0, ALU_OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    tick();
    checkOutput("s6_res_data", 16'(res_data), 16'h07);
    checkOutput("s6_res_rd", 16'(res_rd), 16'h0);
`ifdef ALU_ISSUE_ZCNT_EN
    checkOutput("s6_zcount", zcount, 16'd1);
`endif
    tick();
    applyStimulus(1'b1, ALU_OP_ADD, 3'd0, 3'd0, 3'd7, 1'b0, 8'hFF);
    tick();
    checkOutput("s6_r0_reads_zero", 16'(A), 16'h00);
    checkOutput("s6_r7_not_written", 16'(B), 16'h00);
    applyStimulus(1'b0, ALU_OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    tick();
    checkOutput("s6_final_zero", 16'(res_zero), 16'h1);
`ifdef ALU_ISSUE_ZCNT_EN
    checkOutput("s6_final_zcount", zcount, 16'd2);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
